// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit counter BHT plus an in-order queue of
// in-flight predictions that resolve, train the BHT and raise redirects.
module branch_predictor #(
    parameter int BHT_ENTRIES = 64,
    parameter int INFLIGHT    = 4,
    localparam int TAGW       = $clog2(INFLIGHT),
    localparam int IDXW       = $clog2(BHT_ENTRIES)
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            pred_valid_in,
    input  logic [31:0]     pred_pc_in,
    input  logic [31:0]     pred_target_in,
    output logic            pred_ready_out,
    output logic            pred_rsp_valid_out,
    output logic            pred_taken_out,
    output logic [TAGW-1:0] pred_tag_out,
    input  logic            resolve_valid_in,
    input  logic [TAGW-1:0] resolve_tag_in,
    input  logic            resolve_taken_in,
    output logic            mispredict_out,
    output logic [31:0]     redirect_pc_out,
    output logic            protocol_err_out
);

    localparam logic [TAGW:0] FULL = INFLIGHT[TAGW:0];

    logic [1:0]      bht [BHT_ENTRIES];
    logic [31:0]     q_pc [INFLIGHT];
    logic [31:0]     q_tgt [INFLIGHT];
    logic            q_pred [INFLIGHT];
    logic [TAGW-1:0] head;
    logic [TAGW-1:0] tail;
    logic [TAGW:0]   count;

    logic            legal;
    logic            mis;
    logic            accept;
    logic [1:0]      ctr_rd;
    logic [IDXW-1:0] res_idx;
    logic [1:0]      ctr_old;
    logic [1:0]      ctr_new;

    assign pred_ready_out = count < FULL;
    assign legal   = resolve_valid_in && (count != '0) && (resolve_tag_in == head);
    assign mis     = legal && (resolve_taken_in != q_pred[head]);
    assign accept  = pred_valid_in && pred_ready_out && !mis;
    assign ctr_rd  = bht[pred_pc_in[IDXW+1:2]];
    assign res_idx = q_pc[head][IDXW+1:2];
    assign ctr_old = bht[res_idx];

    always_comb begin
        ctr_new = ctr_old;
        if (resolve_taken_in && ctr_old != 2'b11)
            ctr_new = ctr_old + 2'b01;
        else if (!resolve_taken_in && ctr_old != 2'b00)
            ctr_new = ctr_old - 2'b01;
    end

    // Payload storage needs no reset: count/head gate every read.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            q_pc[tail]   <= pred_pc_in;
            q_tgt[tail]  <= pred_target_in;
            q_pred[tail] <= ctr_rd[1];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht[i] <= 2'b01;
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            pred_rsp_valid_out <= 1'b0;
            pred_taken_out     <= 1'b0;
            pred_tag_out       <= '0;
            mispredict_out     <= 1'b0;
            redirect_pc_out    <= '0;
            protocol_err_out   <= 1'b0;
        end else begin
            pred_rsp_valid_out <= accept;
            mispredict_out     <= mis;
            if (accept) begin
                pred_taken_out <= ctr_rd[1];
                pred_tag_out   <= tail;
            end
            if (legal)
                bht[res_idx] <= ctr_new;
            if (resolve_valid_in && !legal)
                protocol_err_out <= 1'b1;
            if (mis) begin
                redirect_pc_out <= resolve_taken_in ? q_tgt[head]
                                                    : q_pc[head] + 32'd4;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (accept)
                    tail <= tail + 1'b1;
                if (legal)
                    head <= head + 1'b1;
                unique case ({accept, legal})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: prediction, training, flush,
// full-queue back-pressure, protocol errors and mid-cycle reset.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pv;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        ready;
    logic        rsp;
    logic        taken;
    logic [1:0]  tag;
    logic        rv;
    logic [1:0]  rtag;
    logic        rtk;
    logic        mis;
    logic [31:0] redir;
    logic        err;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    branch_predictor #(.BHT_ENTRIES(64), .INFLIGHT(4)) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .pred_valid_in(pv),
        .pred_pc_in(pc),
        .pred_target_in(tgt),
        .pred_ready_out(ready),
        .pred_rsp_valid_out(rsp),
        .pred_taken_out(taken),
        .pred_tag_out(tag),
        .resolve_valid_in(rv),
        .resolve_tag_in(rtag),
        .resolve_taken_in(rtk),
        .mispredict_out(mis),
        .redirect_pc_out(redir),
        .protocol_err_out(err)
    );

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic step(input logic p_v, input logic [31:0] p_pc,
                        input logic [31:0] p_tgt, input logic r_v,
                        input logic [1:0] r_tag, input logic r_tk);
        pv   = p_v;
        pc   = p_pc;
        tgt  = p_tgt;
        rv   = r_v;
        rtag = r_tag;
        rtk  = r_tk;
        @(posedge clk);
        #1;
        pv = 1'b0;
        rv = 1'b0;
    endtask

    task automatic pred(input logic [31:0] p_pc, input logic [31:0] p_tgt);
        step(1'b1, p_pc, p_tgt, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic res(input logic [1:0] r_tag, input logic r_tk);
        step(1'b0, 32'h0, 32'h0, 1'b1, r_tag, r_tk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        pv = 1'b0; pc = '0; tgt = '0;
        rv = 1'b0; rtag = '0; rtk = 1'b0;
        #12;
        chk("rst_rsp", rsp, 0);
        chk("rst_taken", taken, 0);
        chk("rst_tag", tag, 0);
        chk("rst_mis", mis, 0);
        chk("rst_redir", redir, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Training sequence on PC 0x100 (counter index 0, starts at 01)
        pred(32'h100, 32'h200);
        chk("p1_rsp", rsp, 1);
        chk("p1_taken", taken, 0);
        chk("p1_tag", tag, 0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        chk("idle_rsp", rsp, 0);
        res(2'd0, 1'b1);
        chk("r1_mis", mis, 1);
        chk("r1_redir", redir, 32'h200);
        step(1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        chk("r1_pulse", mis, 0);
        chk("r1_hold", redir, 32'h200);
        pred(32'h100, 32'h200);
        chk("p2_taken", taken, 1);
        chk("p2_tag", tag, 0);
        res(2'd0, 1'b1);
        chk("r2_mis", mis, 0);
        chk("r2_hold", redir, 32'h200);
        pred(32'h100, 32'h200);
        chk("p3_taken", taken, 1);
        chk("p3_tag", tag, 1);
        res(2'd1, 1'b1);
        pred(32'h100, 32'h200);
        chk("p4_tag", tag, 2);
        res(2'd2, 1'b1);
        pred(32'h100, 32'h200);
        chk("p5_taken", taken, 1);
        chk("p5_tag", tag, 3);
        res(2'd3, 1'b0);
        chk("r5_mis", mis, 1);
        chk("r5_redir", redir, 32'h104);
        pred(32'h100, 32'h200);
        chk("sat_taken", taken, 1);
        chk("sat_tag", tag, 0);
        res(2'd0, 1'b0);
        chk("r6_mis", mis, 1);

        // Fill the queue with not-taken predictions
        pred(32'h204, 32'h0);
        chk("f0_tag", tag, 0);
        pred(32'h208, 32'h0);
        chk("f1_tag", tag, 1);
        pred(32'h20C, 32'h0);
        chk("f2_tag", tag, 2);
        pred(32'h210, 32'h0);
        chk("f3_tag", tag, 3);
        chk("f3_taken", taken, 0);
        chk("full_ready", ready, 0);
        pred(32'h214, 32'h0);
        chk("full_drop", rsp, 0);
        res(2'd0, 1'b0);
        chk("pop0_mis", mis, 0);
        chk("pop0_ready", ready, 1);
        step(1'b1, 32'h214, 32'h0, 1'b1, 2'd1, 1'b0);
        chk("pp_rsp", rsp, 1);
        chk("pp_tag", tag, 0);
        chk("pp_ready", ready, 1);
        pred(32'h218, 32'h0);
        chk("pp2_tag", tag, 1);
        chk("pp2_ready", ready, 0);
        res(2'd0, 1'b1);
        chk("bad_tag_err", err, 1);
        chk("bad_tag_mis", mis, 0);
        chk("bad_tag_ready", ready, 0);
        res(2'd2, 1'b0);
        chk("pop2_ready", ready, 1);
        chk("err_sticky", err, 1);
        step(1'b1, 32'h21C, 32'h0, 1'b1, 2'd3, 1'b0);
        chk("pp3_rsp", rsp, 1);
        chk("pp3_tag", tag, 2);

        // Reset between edges with three entries in flight
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_rsp", rsp, 0);
        chk("mr_tag", tag, 0);
        chk("mr_err", err, 0);
        chk("mr_redir", redir, 0);
        chk("mr_ready", ready, 1);
        @(posedge clk);
        #1;
        chk("mr_mis", mis, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_ready", ready, 1);
        chk("rel_mis", mis, 0);
        chk("rel_rsp", rsp, 0);

        // Resolve on an empty queue must not train
        res(2'd0, 1'b1);
        chk("empty_err", err, 1);
        chk("empty_mis", mis, 0);
        pred(32'h100, 32'h200);
        chk("empty_bht", taken, 0);
        chk("empty_tag", tag, 0);
        res(2'd0, 1'b0);
        chk("e_res_mis", mis, 0);

        // Wrap-around PC redirect with a dropped same-cycle request
        pred(32'hFFFFFFFC, 32'h40);
        chk("w1_taken", taken, 0);
        chk("w1_tag", tag, 1);
        res(2'd1, 1'b1);
        chk("w1_mis", mis, 1);
        chk("w1_redir", redir, 32'h40);
        pred(32'hFFFFFFFC, 32'h40);
        chk("w2_taken", taken, 1);
        chk("w2_tag", tag, 0);
        pred(32'h300, 32'h0);
        chk("w3_taken", taken, 0);
        chk("w3_tag", tag, 1);
        step(1'b1, 32'h304, 32'h0, 1'b1, 2'd0, 1'b0);
        chk("wrap_mis", mis, 1);
        chk("wrap_redir", redir, 32'h0);
        chk("wrap_drop", rsp, 0);
        chk("wrap_ready", ready, 1);
        pred(32'h308, 32'h0);
        chk("after_tag", tag, 0);
        chk("after_rsp", rsp, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
